// File: rtl/nni_pkg.sv
`default_nettype none
// ==========================================================================
// nni_pkg: cell constants and transmit FSM state shared by NNI TX/RX. Rev 1.0
// ==========================================================================
package nni_pkg;
    localparam int         CELL_BYTES = 53;
    localparam int         CELL_W     = 424;
    localparam int         HDR_BYTES  = 4;
    localparam logic [7:0] HEC_POLY   = 8'h07;
    localparam logic [7:0] HEC_COSET  = 8'h55;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SEND  = 2'd3
    } tx_state_t;
endpackage
`default_nettype wire

// File: rtl/hec_gen.sv
`default_nettype none
// ==========================================================================
// hec_gen: combinational CRC-8 (0x07) header HEC with coset applied. Rev 1.0
// ==========================================================================
module hec_gen
    import nni_pkg::*;
(
    input  logic [8*HDR_BYTES-1:0] hdr,
    output logic [7:0]             hec
);

    logic [7:0] w_crc;

    always_comb begin
        w_crc = 8'h00;
        for (int i = 8*HDR_BYTES-1; i >= 0; i--) begin
            w_crc = {w_crc[6:0], 1'b0} ^ ((w_crc[7] ^ hdr[i]) ? HEC_POLY : 8'h00);
        end
        hec = w_crc ^ HEC_COSET;
    end

endmodule
`default_nettype wire

// File: rtl/nni_tx_serializer.sv
`default_nettype none
// ==========================================================================
// nni_tx_serializer: pops 53-byte cells and sends them MSB byte first. Rev 1.0
// ==========================================================================
module nni_tx_serializer
    import nni_pkg::*;
#(
    parameter int HEC_GEN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [CELL_W-1:0] fifo_data,
    output logic [7:0]        tx_data,
    output logic              tx_soc,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  cell_cnt
);

    localparam logic [5:0] c_last_idx = 6'(CELL_BYTES - 1);

    tx_state_t         r_state;
    logic [CELL_W-1:0] r_cell;
    logic [5:0]        r_byte_idx;
    logic [CNT_W-1:0]  r_cell_cnt;
    logic              r_rd_en;
    logic              r_valid;
    logic              r_soc;
    logic              r_busy;
    logic [7:0]        w_hec;
    logic [CELL_W-1:0] w_cell_in;

    hec_gen u_hec_gen (
        .hdr (fifo_data[CELL_W-1 -: 8*HDR_BYTES]),
        .hec (w_hec)
    );

    always_comb begin
        w_cell_in = fifo_data;
        if (HEC_GEN != 0) begin
            w_cell_in[CELL_W-8*HDR_BYTES-1 -: 8] = w_hec;
        end
    end

    // The cell register shifts left on every accepted byte, so the current
    // byte is always the top byte and it drains to zero after byte 52.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cell     <= '0;
            r_byte_idx <= '0;
            r_cell_cnt <= '0;
            r_rd_en    <= 1'b0;
            r_valid    <= 1'b0;
            r_soc      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_state <= ST_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_cell     <= w_cell_in;
                    r_byte_idx <= '0;
                    r_valid    <= 1'b1;
                    r_soc      <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        r_soc  <= 1'b0;
                        r_cell <= {r_cell[CELL_W-9:0], 8'h00};
                        if (r_byte_idx == c_last_idx) begin
                            r_cell_cnt <= r_cell_cnt + CNT_W'(1);
                            r_valid    <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 6'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx_data    = r_cell[CELL_W-1 -: 8];
    assign tx_soc     = r_soc;
    assign tx_valid   = r_valid;
    assign busy       = r_busy;
    assign cell_cnt   = r_cell_cnt;

endmodule
`default_nettype wire
